scan_capture: RTL and testbench
===============================

# scan_capture

Receiving end of the converter's multiplexed digit output. It watches the end-of-conversion flag, the four one-hot digit strobes and the shared 4-bit digit bus, then reassembles one 3½-digit reading with polarity and overrange. Frames are checked for strobe order, one-hot strobes, BCD range and timeout. A good frame is published as one parallel result with a single-cycle valid pulse, for the display and host-side logic.

## Interface
Parameters:
- CNT_W, 10: width of the inter-strobe timeout counter. Timeout occurs when the counter reaches 2^CNT_W−1.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- R6  input  1  asynchronous, active-low reset.
- eoc  input  1  end-of-conversion flag from the converter; active high.
- ds  input  4  digit strobes, one-hot. ds[0]=DS1 (MSD), ds[3]=DS4 (LSD).
- q  input  4  digit bus, valid while its strobe is high.
- half  output  1  ½ digit (MSD), 0 or 1.
- d2, d1, d0  output  4 each  BCD digits, hundreds/tens/units.
- pos  output  1  polarity; 1 means positive.
- ovr  output  1  overrange flag.
- valid  output  1  one-cycle pulse when the outputs above update.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- busy  output  1  high while a frame is being collected.

## Operation
Edge detection:
- eoc and ds are sampled every cycle and compared with the previous sample.
- An "edge" is a 0→1 transition on a sampled bit.

DS1 word encoding:
- q[3] = half.
- q[2] = pos.
- q[0] = ovr.
- q[1] is ignored.

DS2–DS4 words: BCD, must be ≤ 9.

FSM states: IDLE, W1, W2, W3, W4.
- IDLE: busy=0. On an eoc edge → W1 and clear the timeout counter.
- Wn (n=1..4): waiting for a ds[n−1] edge.
  - On that edge, capture q into a shadow register for that digit.
  - Then go to W(n+1), or, from W4, publish.
  - Clear the counter on each accepted edge.
- Publish:
  - Copy the shadow registers to the outputs.
  - Pulse valid.
  - Return to IDLE.

Errors (pulse frame_err, discard the shadow registers, outputs unchanged):
- In any Wn: a ds edge on any bit other than ds[n−1] → IDLE.
- Sampled ds with more than one bit set → IDLE.
- BCD value > 9 captured in W2–W4 → IDLE.
- Counter reaches 2^CNT_W−1 → IDLE.
- eoc edge while in W1–W4 → restart at W1 with the counter cleared. This counts as an error.

Precedence and corner cases:
- Simultaneous eoc edge and ds[0] edge in the same cycle while in IDLE: treated as eoc first. The DS1 capture happens in that same cycle, so the state goes straight to W2.
- Strobe edges in IDLE without an eoc edge are ignored, with no error.
- Outputs hold the last published frame indefinitely.

## Timing
- Reset (R6=0), applied asynchronously:
  - state IDLE.
  - half, d2, d1, d0, pos, ovr, valid, frame_err, busy all 0.
  - Sample registers and timeout counter 0.
- Reset mid-frame aborts the frame silently: no frame_err.
- Latency:
  - Input change → sample register: 1 cycle.
  - Sample edge → state/shadow update: same edge as the detection compare.
  - valid and the new outputs appear together, 1 cycle after the cycle where the DS4 edge is detected. That is 2 clk edges after ds[3] rises at the pin.
- frame_err uses the same latency relative to the offending sample.
- busy is high from the cycle after the eoc edge is detected until valid or frame_err.
- The timeout counter increments every cycle in W1–W4 and saturates at the error event.
- Back-to-back frames are allowed. A new eoc edge may arrive in the cycle after valid.

## Configuration
SCAN_SYNC_EN:
- Defined: eoc, ds and q each pass through a two-flop synchronizer, reset to 0 by R6, before edge detection. All latencies grow by 2 cycles. Use this for asynchronous converter pins.
- Undefined: inputs are assumed synchronous to clk and go directly to the sample registers.

## Test plan
- Good frame: eoc↑, then DS1 q=4'b1100, DS2 q=9, DS3 q=8, DS4 q=7, each strobe 3 cycles wide → one valid pulse; half=1, pos=1, ovr=0, d2=9, d1=8, d0=7; busy drops with valid.
- Out of order: eoc↑, DS1, then DS3 before DS2 → frame_err pulse; outputs keep the previous frame; state IDLE.
- Bad BCD: DS3 word = 4'hA → frame_err; then a full good frame → valid with the new values.
- Timeout: CNT_W=4, eoc↑, DS1, then no strobe for 15 cycles → frame_err exactly once; busy=0.
- eoc↑ mid-frame after DS2: frame_err, then a complete DS1–DS4 sequence → valid with only the second frame's data. The simultaneous eoc↑+DS1↑ case also yields valid.
- R6 pulsed low mid-frame → all outputs 0 immediately, no frame_err. Repeat the good frame with SCAN_SYNC_EN defined → valid arrives 2 cycles later than without it.

Source files
------------

// File: rtl/scan_capture.sv
// scan_capture: receiving end of the converter's multiplexed digit output.
//
// Watches the end-of-conversion flag, the four one-hot digit strobes and the
// shared digit bus, reassembles one 3 1/2 digit reading (half digit, three BCD
// digits, polarity, overrange) and publishes it with a one-cycle valid pulse.
// Frames with stray or overlapping strobes, non-BCD digits or a stalled
// strobe sequence are discarded with a one-cycle frame_err pulse.
//
// Optional feature macro: SCAN_SYNC_EN
//   defined   - eoc, ds and q each pass through a two-flop synchronizer first
//               (all latencies grow by two cycles).
//   undefined - inputs are taken as synchronous to clk.
//
// Parameters:
//   CNT_W      width of the inter-strobe timeout counter; a frame times out
//              when the counter reaches 2^CNT_W-1.
// Ports:
//   clk        clock, rising edge
//   R6         asynchronous active-low reset
//   eoc        end-of-conversion flag (active high)
//   ds[3:0]    one-hot digit strobes, ds[0]=DS1 (MSD) .. ds[3]=DS4 (LSD)
//   q[3:0]     digit bus, valid while its strobe is high
//   half       half digit of the last published reading
//   d2/d1/d0   BCD hundreds/tens/units of the last published reading
//   pos        polarity of the last published reading, 1 = positive
//   ovr        overrange flag of the last published reading
//   valid      one-cycle pulse when the reading outputs update
//   frame_err  one-cycle pulse when a frame is discarded
//   busy       high while a frame is being collected
module scan_capture #(
    parameter int unsigned CNT_W = 10
) (
    input  logic       clk,
    input  logic       R6,
    input  logic       eoc,
    input  logic [3:0] ds,
    input  logic [3:0] q,
    output logic       half,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       pos,
    output logic       ovr,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StW1, StW2, StW3, StW4} state_e;

    logic       eoc_in;
    logic [3:0] ds_in;
    logic [3:0] q_in;

`ifdef SCAN_SYNC_EN
    logic       eoc_m_q, eoc_y_q;
    logic [3:0] ds_m_q, ds_y_q;
    logic [3:0] q_m_q, q_y_q;

    always_ff @(posedge clk or negedge R6) begin
        if (!R6) begin
            eoc_m_q <= 1'b0;
            eoc_y_q <= 1'b0;
            ds_m_q  <= 4'd0;
            ds_y_q  <= 4'd0;
            q_m_q   <= 4'd0;
            q_y_q   <= 4'd0;
        end else begin
            eoc_m_q <= eoc;
            eoc_y_q <= eoc_m_q;
            ds_m_q  <= ds;
            ds_y_q  <= ds_m_q;
            q_m_q   <= q;
            q_y_q   <= q_m_q;
        end
    end

    assign eoc_in = eoc_y_q;
    assign ds_in  = ds_y_q;
    assign q_in   = q_y_q;
`else
    assign eoc_in = eoc;
    assign ds_in  = ds;
    assign q_in   = q;
`endif

    // Current sample (_s) and previous sample (_p) for rising-edge detection.
    logic       eoc_s_q, eoc_p_q;
    logic [3:0] ds_s_q, ds_p_q;
    logic [3:0] q_s_q;

    always_ff @(posedge clk or negedge R6) begin
        if (!R6) begin
            eoc_s_q <= 1'b0;
            eoc_p_q <= 1'b0;
            ds_s_q  <= 4'd0;
            ds_p_q  <= 4'd0;
            q_s_q   <= 4'd0;
        end else begin
            eoc_s_q <= eoc_in;
            eoc_p_q <= eoc_s_q;
            ds_s_q  <= ds_in;
            ds_p_q  <= ds_s_q;
            q_s_q   <= q_in;
        end
    end

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sh_half_q, sh_pos_q, sh_ovr_q;
    logic [3:0]       sh_d2_q, sh_d1_q;

    logic       eoc_edge;
    logic [3:0] ds_edge;
    logic [3:0] exp_bit;
    logic       ds_multi;
    logic       hit;
    logic       stray;
    logic       bcd_bad;
    logic       timeout;
    logic       in_frame;
    logic       abort;

    always_comb begin
        exp_bit = 4'b0000;
        unique case (state_q)
            StW1:    exp_bit = 4'b0001;
            StW2:    exp_bit = 4'b0010;
            StW3:    exp_bit = 4'b0100;
            StW4:    exp_bit = 4'b1000;
            default: exp_bit = 4'b0000;
        endcase
    end

    assign eoc_edge = eoc_s_q & ~eoc_p_q;
    assign ds_edge  = ds_s_q & ~ds_p_q;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign ds_multi = (ds_s_q & (ds_s_q - 4'd1)) != 4'd0;
    assign hit      = |(ds_edge & exp_bit);
    assign stray    = |(ds_edge & ~exp_bit);
    assign bcd_bad  = (state_q != StW1) && (q_s_q > 4'd9);
    assign timeout  = (cnt_q == CNT_MAX);
    assign in_frame = (state_q != StIdle);
    // A good strobe edge in the same cycle as the timeout still counts.
    assign abort    = in_frame && (eoc_edge || ds_multi || stray || (hit && bcd_bad) ||
                                   (!hit && timeout));

    always_ff @(posedge clk or negedge R6) begin
        if (!R6) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            sh_half_q <= 1'b0;
            sh_pos_q  <= 1'b0;
            sh_ovr_q  <= 1'b0;
            sh_d2_q   <= 4'd0;
            sh_d1_q   <= 4'd0;
            half      <= 1'b0;
            pos       <= 1'b0;
            ovr       <= 1'b0;
            d2        <= 4'd0;
            d1        <= 4'd0;
            d0        <= 4'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            frame_err <= 1'b0;
            if (!in_frame) begin
                // Strobes without a preceding eoc edge are ignored here.
                if (eoc_edge) begin
                    cnt_q <= '0;
                    busy  <= 1'b1;
                    if (ds_edge == 4'b0001 && !ds_multi) begin
                        sh_half_q <= q_s_q[3];
                        sh_pos_q  <= q_s_q[2];
                        sh_ovr_q  <= q_s_q[0];
                        state_q   <= StW2;
                    end else begin
                        state_q <= StW1;
                    end
                end
            end else if (abort) begin
                frame_err <= 1'b1;
                sh_half_q <= 1'b0;
                sh_pos_q  <= 1'b0;
                sh_ovr_q  <= 1'b0;
                sh_d2_q   <= 4'd0;
                sh_d1_q   <= 4'd0;
                if (eoc_edge) begin
                    // A fresh conversion restarts collection instead of idling.
                    state_q <= StW1;
                    cnt_q   <= '0;
                end else begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            end else if (hit) begin
                cnt_q <= '0;
                unique case (state_q)
                    StW1: begin
                        sh_half_q <= q_s_q[3];
                        sh_pos_q  <= q_s_q[2];
                        sh_ovr_q  <= q_s_q[0];
                        state_q   <= StW2;
                    end
                    StW2: begin
                        sh_d2_q <= q_s_q;
                        state_q <= StW3;
                    end
                    StW3: begin
                        sh_d1_q <= q_s_q;
                        state_q <= StW4;
                    end
                    default: begin
                        half    <= sh_half_q;
                        pos     <= sh_pos_q;
                        ovr     <= sh_ovr_q;
                        d2      <= sh_d2_q;
                        d1      <= sh_d1_q;
                        d0      <= q_s_q;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end else begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_scan_capture.sv
// Self-checking bench for scan_capture: directed latency, timeout and reset
// cases plus randomized good and bad frames checked against a frame-level
// reference model.
module tb_scan_capture;

    localparam int unsigned CNT_W = 4;
`ifdef SCAN_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       R6 = 1'b0;
    logic       eoc = 1'b0;
    logic [3:0] ds = 4'd0;
    logic [3:0] q = 4'd0;
    logic       half, pos, ovr, valid, frame_err, busy;
    logic [3:0] d2, d1, d0;

    scan_capture #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .R6        (R6),
        .eoc       (eoc),
        .ds        (ds),
        .q         (q),
        .half      (half),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .pos       (pos),
        .ovr       (ovr),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int n_valid = 0;
    int n_err = 0;
    logic [14:0] model_pub = 15'd0;

    always @(negedge clk) begin
        if (valid) n_valid++;
        if (frame_err) n_err++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reading as {half, pos, ovr, d2, d1, d0} built from the DS1 word rules.
    function automatic logic [14:0] reading(input logic [3:0] w, input logic [3:0] a,
                                            input logic [3:0] b, input logic [3:0] c);
        return {w[3], w[2], w[0], a, b, c};
    endfunction

    function automatic int outs();
        return int'({half, pos, ovr, d2, d1, d0});
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_eoc();
        eoc = 1'b1;
        tick(2);
        eoc = 1'b0;
        tick(1);
    endtask

    task automatic send_digit(input int idx, input logic [3:0] val);
        q  = val;
        ds = 4'(1 << idx);
        tick(3);
        ds = 4'd0;
        tick($urandom_range(3, 0));
    endtask

    task automatic send_all(input logic [3:0] w, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c);
        send_digit(0, w);
        send_digit(1, a);
        send_digit(2, b);
        send_digit(3, c);
    endtask

    task automatic run_frame(input int kind);
        logic [3:0] dig [4];
        int nv0, ne0, exp_v, exp_e, p;
        dig[0] = 4'($urandom);
        dig[1] = 4'($urandom_range(9, 0));
        dig[2] = 4'($urandom_range(9, 0));
        dig[3] = 4'($urandom_range(9, 0));
        nv0 = n_valid;
        ne0 = n_err;
        exp_v = 0;
        exp_e = 0;
        case (kind)
            0: begin
                send_eoc();
                send_all(dig[0], dig[1], dig[2], dig[3]);
                exp_v = 1;
                model_pub = reading(dig[0], dig[1], dig[2], dig[3]);
            end
            1: begin
                p = $urandom_range(3, 1);
                dig[p] = 4'($urandom_range(15, 10));
                send_eoc();
                send_all(dig[0], dig[1], dig[2], dig[3]);
                exp_e = 1;
            end
            2: begin
                send_eoc();
                send_digit(0, dig[0]);
                send_digit(2, dig[2]);
                send_digit(1, dig[1]);
                send_digit(3, dig[3]);
                exp_e = 1;
            end
            3: begin
                send_eoc();
                send_digit(0, dig[0]);
                q  = dig[1];
                ds = 4'b0110;
                tick(3);
                ds = 4'd0;
                tick(1);
                exp_e = 1;
            end
            4: begin
                send_eoc();
                send_digit(0, 4'($urandom));
                send_digit(1, 4'($urandom_range(9, 0)));
                send_eoc();
                send_all(dig[0], dig[1], dig[2], dig[3]);
                exp_e = 1;
                exp_v = 1;
                model_pub = reading(dig[0], dig[1], dig[2], dig[3]);
            end
            default: begin
                eoc = 1'b1;
                ds  = 4'b0001;
                q   = dig[0];
                tick(2);
                eoc = 1'b0;
                tick(1);
                ds = 4'd0;
                tick(1);
                send_digit(1, dig[1]);
                send_digit(2, dig[2]);
                send_digit(3, dig[3]);
                exp_v = 1;
                model_pub = reading(dig[0], dig[1], dig[2], dig[3]);
            end
        endcase
        tick(LAT + 3);
        check($sformatf("k%0d_valid_cnt", kind), n_valid - nv0, exp_v);
        check($sformatf("k%0d_err_cnt", kind), n_err - ne0, exp_e);
        check($sformatf("k%0d_outputs", kind), outs(), int'(model_pub));
        check($sformatf("k%0d_busy", kind), int'(busy), 0);
        tick(2);
    endtask

    initial begin
        int nv0, ne0;

        // Reset state
        tick(3);
        check("rst_outputs", outs(), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(frame_err), 0);
        check("rst_busy", int'(busy), 0);
        R6 = 1'b1;
        tick(3);

        // Good frame with exact output latency
        nv0 = n_valid;
        send_eoc();
        check("busy_after_eoc", int'(busy), 1);
        send_digit(0, 4'b1100);
        send_digit(1, 4'd9);
        send_digit(2, 4'd8);
        q  = 4'd7;
        ds = 4'b1000;
        tick(LAT - 1);
        check("valid_early", int'(valid), 0);
        check("busy_before_valid", int'(busy), 1);
        tick(1);
        check("valid_on_time", int'(valid), 1);
        check("busy_drops", int'(busy), 0);
        check("good_half", int'(half), 1);
        check("good_pos", int'(pos), 1);
        check("good_ovr", int'(ovr), 0);
        check("good_digits", int'({d2, d1, d0}), 'h987);
        model_pub = reading(4'b1100, 4'd9, 4'd8, 4'd7);
        tick(1);
        check("valid_one_cycle", int'(valid), 0);
        ds = 4'd0;
        tick(3);
        check("good_valid_cnt", n_valid - nv0, 1);

        // Stray strobe edges in idle are ignored
        ne0 = n_err;
        send_digit(2, 4'd3);
        send_digit(0, 4'd1);
        tick(LAT + 2);
        check("idle_strobe_err", n_err - ne0, 0);
        check("idle_strobe_outs", outs(), int'(model_pub));

        // Timeout after DS1
        ne0 = n_err;
        nv0 = n_valid;
        send_eoc();
        q  = 4'b0101;
        ds = 4'b0001;
        tick(3);
        ds = 4'd0;
        tick(30);
        check("timeout_err_cnt", n_err - ne0, 1);
        check("timeout_valid_cnt", n_valid - nv0, 0);
        check("timeout_busy", int'(busy), 0);
        check("timeout_outs", outs(), int'(model_pub));

        // Randomized frames of every kind
        for (int i = 0; i < 36; i++) begin
            run_frame((i < 6) ? i : int'($urandom_range(5, 0)));
        end

        // Reset mid-frame: outputs clear at once, no error pulse
        ne0 = n_err;
        send_eoc();
        send_digit(0, 4'b1101);
        send_digit(1, 4'd4);
        #2;
        R6 = 1'b0;
        #1;
        check("midrst_outputs", outs(), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        tick(2);
        R6 = 1'b1;
        model_pub = 15'd0;
        tick(4);
        check("midrst_err_cnt", n_err - ne0, 0);
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
